// File: rtl/brl_arb.sv
// Arbiter/sequencer for the shared 32-bit barrel shifter (IDLE -> EXEC -> DONE).
// Define BRL_ARB_FIXPRI_EN for fixed priority (requester 0 wins ties, no pointer).
module brl_arb (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_0,
    input  logic [1:0]  mode_0,
    input  logic [0:31] cnt_0,
    input  logic [0:31] dat_0,
    input  logic        req_1,
    input  logic [1:0]  mode_1,
    input  logic [0:31] cnt_1,
    input  logic [0:31] dat_1,
    output logic        ack_0,
    output logic        ack_1,
    output logic [0:31] resq,
    output logic        resc,
    output logic        busy,
    output logic        brlmux_0,
    output logic        brlmux_1,
    output logic [0:31] srcdp,
    output logic [0:31] brld,
    input  logic [0:31] brlq,
    input  logic        brl_carry
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic        gnt;
    logic        win;
    logic [1:0]  op_mode;
    logic [0:31] op_cnt;
    logic [0:31] op_dat;
`ifndef BRL_ARB_FIXPRI_EN
    logic        ptr;
`endif

    // Winner is only meaningful when at least one request is high.
    always_comb begin
        win = 1'b0;
`ifdef BRL_ARB_FIXPRI_EN
        win = ~req_0;
`else
        if (req_0 && req_1)
            win = ~ptr;
        else
            win = req_1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            gnt     <= 1'b0;
            op_mode <= '0;
            op_cnt  <= '0;
            op_dat  <= '0;
            ack_0   <= 1'b0;
            ack_1   <= 1'b0;
            resq    <= '0;
            resc    <= 1'b0;
            busy    <= 1'b0;
`ifndef BRL_ARB_FIXPRI_EN
            ptr     <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ack_0 <= 1'b0;
                    ack_1 <= 1'b0;
                    if (req_0 || req_1) begin
                        gnt     <= win;
                        op_mode <= win ? mode_1 : mode_0;
                        op_cnt  <= win ? cnt_1  : cnt_0;
                        op_dat  <= win ? dat_1  : dat_0;
                        state   <= EXEC;
                        busy    <= 1'b1;
`ifndef BRL_ARB_FIXPRI_EN
                        if (req_0 && req_1)
                            ptr <= win;
`endif
                    end
                end
                EXEC: begin
                    // Shifter has settled on the operand registers; capture and ack in DONE.
                    resq  <= brlq;
                    resc  <= brl_carry;
                    ack_0 <= ~gnt;
                    ack_1 <= gnt;
                    state <= DONE;
                end
                DONE: begin
                    ack_0 <= 1'b0;
                    ack_1 <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ack_0 <= 1'b0;
                    ack_1 <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign brlmux_0 = op_mode[0];
    assign brlmux_1 = op_mode[1];
    assign srcdp    = op_cnt;
    assign brld     = op_dat;

endmodule

// File: tb/tb_brl_arb.sv
// Self-checking bench for brl_arb: directed scenarios plus randomized traffic
// against a transaction-level reference model; honours BRL_ARB_FIXPRI_EN.
module tb_brl_arb;

    logic        clk;
    logic        reset;
    logic        rq [0:1];
    logic [1:0]  md [0:1];
    logic [31:0] ct [0:1];
    logic [31:0] dt [0:1];

    logic        ack_0, ack_1, resc, busy, brlmux_0, brlmux_1, brl_carry;
    logic [0:31] resq, srcdp, brld, brlq;
    logic        req_0, req_1;
    logic [1:0]  mode_0, mode_1;
    logic [0:31] cnt_0, cnt_1, dat_0, dat_1;

    int n_chk = 0;
    int n_fail = 0;

    assign req_0 = rq[0];  assign mode_0 = md[0];  assign cnt_0 = ct[0];  assign dat_0 = dt[0];
    assign req_1 = rq[1];  assign mode_1 = md[1];  assign cnt_1 = ct[1];  assign dat_1 = dt[1];

    brl_arb dut (
        .clk(clk), .reset(reset),
        .req_0(req_0), .mode_0(mode_0), .cnt_0(cnt_0), .dat_0(dat_0),
        .req_1(req_1), .mode_1(mode_1), .cnt_1(cnt_1), .dat_1(dat_1),
        .ack_0(ack_0), .ack_1(ack_1), .resq(resq), .resc(resc), .busy(busy),
        .brlmux_0(brlmux_0), .brlmux_1(brlmux_1), .srcdp(srcdp), .brld(brld),
        .brlq(brlq), .brl_carry(brl_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in shifter: any deterministic function of mode/count/data will do.
    function automatic logic [32:0] shf(input logic [1:0] m, input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = m[0] ? (d << c[4:0]) : (d >> c[4:0]);
        if (m[1]) r = ~r;
        return {(^c) ^ m[0] ^ d[0], r};
    endfunction

    assign {brl_carry, brlq} = shf({brlmux_1, brlmux_0}, srcdp, brld);

    // Reference model: one transaction in flight, tracked by its age in cycles.
    logic        m_act, m_who, m_ptr, m_car;
    int          m_age;
    logic [1:0]  m_mode;
    logic [31:0] m_cnt, m_dat, m_res;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        logic w;
        @(posedge clk);
        if (reset) begin
            m_act = 0; m_age = 0; m_who = 0; m_ptr = 1;
            m_mode = '0; m_cnt = '0; m_dat = '0; m_res = '0; m_car = 0;
        end else if (m_act) begin
            if (m_age == 1) begin
                {m_car, m_res} = shf(m_mode, m_cnt, m_dat);
                m_age = 2;
            end else begin
                m_act = 0;
            end
        end else if (rq[0] || rq[1]) begin
            if (rq[0] && rq[1]) begin
`ifdef BRL_ARB_FIXPRI_EN
                w = 0;
`else
                w = (m_ptr == 1'b0);
                m_ptr = w;
`endif
            end else begin
                w = rq[1];
            end
            m_who = w; m_act = 1; m_age = 1;
            m_mode = md[w]; m_cnt = ct[w]; m_dat = dt[w];
        end
        @(negedge clk);
        check("busy",  32'(busy),  32'(m_act));
        check("ack_0", 32'(ack_0), 32'(m_act && m_age == 2 && m_who == 0));
        check("ack_1", 32'(ack_1), 32'(m_act && m_age == 2 && m_who == 1));
        check("resq",  resq,       m_res);
        check("resc",  32'(resc),  32'(m_car));
        check("srcdp", srcdp,      m_cnt);
        check("brld",  brld,       m_dat);
        check("mux0",  32'(brlmux_0), 32'(m_mode[0]));
        check("mux1",  32'(brlmux_1), 32'(m_mode[1]));
    endtask

    task automatic new_op(input int x);
        rq[x] = 1'b1;
        md[x] = 2'($urandom_range(3));
        ct[x] = $urandom;
        dt[x] = $urandom;
    endtask

    initial begin
        int acks;
        int order [$];
        logic own;
        for (int i = 0; i < 2; i++) begin
            rq[i] = 0; md[i] = '0; ct[i] = '0; dt[i] = '0;
        end
        m_act = 0; m_age = 0; m_who = 0; m_ptr = 1;
        m_mode = '0; m_cnt = '0; m_dat = '0; m_res = '0; m_car = 0;

        reset = 1; step(); step();
        reset = 0; step();

        // Reset while EXEC discards the operation
        rq[1] = 1; md[1] = 2'b01; ct[1] = 32'hFFFF_FFFE; dt[1] = 32'h1234_5678;
        step();
        check("t4_srcdp_exec", srcdp, 32'hFFFF_FFFE);
        rq[1] = 0; reset = 1;
        step();
        reset = 0;
        check("t4_busy", 32'(busy), 0);
        check("t4_resq", resq, 0);
        check("t4_srcdp", srcdp, 0);
        step();
        check("t4_no_ack", 32'(ack_1), 0);

        // Single op from requester 0
        rq[0] = 1; md[0] = 2'b10; ct[0] = 32'd4; dt[0] = 32'h8000_0001;
        step();
        check("t1_mux0", 32'(brlmux_0), 0);
        check("t1_mux1", 32'(brlmux_1), 1);
        check("t1_srcdp", srcdp, 4);
        check("t1_ack_early", 32'(ack_0), 0);
        step();
        check("t1_ack", 32'(ack_0), 1);
        check("t1_ack1", 32'(ack_1), 0);
        check("t1_resq", resq, 32'hF7FF_FFFF);
        check("t1_resc", 32'(resc), 0);
        rq[0] = 0;
        step();

        // One-cycle request pulse still completes exactly once
        new_op(0);
        step();
        rq[0] = 0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (ack_0) acks++;
        end
        check("t5_ack_count", 32'(acks), 1);

        // Both requesting continuously: grant order
        new_op(0); new_op(1);
        for (int i = 0; i < 12 && order.size() < 3; i++) begin
            step();
            if (ack_0) order.push_back(0);
            if (ack_1) order.push_back(1);
        end
        check("t2_ops", 32'(order.size()), 3);
        if (order.size() == 3) begin
`ifdef BRL_ARB_FIXPRI_EN
            check("t3_order0", 32'(order[0]), 0);
            check("t3_order1", 32'(order[1]), 0);
            check("t3_order2", 32'(order[2]), 0);
`else
            check("t2_order0", 32'(order[0]), 0);
            check("t2_order1", 32'(order[1]), 1);
            check("t2_order2", 32'(order[2]), 0);
`endif
        end
        rq[0] = 0; rq[1] = 0;
        step(); step(); step();

        // Randomized traffic with occasional resets
        for (int n = 0; n < 800; n++) begin
            for (int x = 0; x < 2; x++) begin
                own = m_act && (m_who == 1'(x));
                if (rq[x]) begin
                    if (own && m_age == 2) begin
                        if ($urandom_range(1) == 1) new_op(x);
                        else rq[x] = 0;
                    end else if (own && $urandom_range(3) == 0) begin
                        rq[x] = 0;
                    end
                end else if (!own && $urandom_range(2) == 0) begin
                    new_op(x);
                end
            end
            reset = ($urandom_range(49) == 0);
            step();
        end
        reset = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
